seg7_leitor_filtrado: RTL and testbench
=======================================

// Module: seg7_leitor_filtrado
// PURPOSE
//  Reads back a 7-segment pattern bus (active-low, bit6=a .. bit0=g) and recovers the BCD digit.
//  Applies a stability filter: a new pattern is accepted only after it has been held for
//  STABLE_CYCLES consecutive samples. Used on a display-side test/monitor path to check and count
//  digits driven by the counter+decoder datapath.
// PARAMETERS
//  STABLE_CYCLES  4  consecutive equal samples required to accept a pattern (legal 1..255)
//  CNT_W          8  width of change_cnt (and err_cnt when enabled)
// PORTS
//  clk          in   1      system clock, all logic on posedge
//  rst          in   1      synchronous reset, active-high
//  seg_in       in   7      segment pattern, active-low, {a,b,c,d,e,f,g}
//  sample_en    in   1      sampling strobe; 0 = freeze all state and outputs
//  digit        out  4      last accepted decimal digit 0..9
//  digit_valid  out  1      1 = last accepted pattern was a legal digit
//  blank        out  1      1 = last accepted pattern was 7'b1111111
//  pattern_err  out  1      1 = last accepted pattern was neither digit nor blank
//  new_digit    out  1      1-cycle pulse on acceptance of a digit differing from the previous
//  change_cnt   out  CNT_W  number of new_digit pulses since reset, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset (rst=1 at posedge, dominates sample_en): state=EMPTY, cand=7'b1111111, stab_cnt=0,
//   digit=0, digit_valid=0, blank=0, pattern_err=0, new_digit=0, change_cnt=0.
//  Legal table (seg_in -> digit): 0000001->0 1001111->1 0010010->2 0000110->3 1001100->4
//   0100100->5 0100000->6 0001111->7 0000000->8 0000100->9; 1111111 -> blank; other -> error.
//  Filter per posedge with sample_en=1:
//   seg_in!=cand: cand<=seg_in, stab_cnt<=1, state->SETTLE (from any state).
//   seg_in==cand and stab_cnt<STABLE_CYCLES: stab_cnt<=stab_cnt+1.
//   Acceptance fires on the edge where stab_cnt becomes STABLE_CYCLES (incl. load edge when
//   STABLE_CYCLES=1); state->LOCKED; stab_cnt saturates, no re-accept while LOCKED.
//  Latency: pattern first sampled at edge k -> outputs updated at edge k+STABLE_CYCLES-1.
//  States: EMPTY (nothing accepted since reset), SETTLE (counting), LOCKED (accepted, stable).
//   EMPTY->SETTLE on differing sample; EMPTY/SETTLE->LOCKED on acceptance; LOCKED->SETTLE on change.
//  On acceptance (outputs change only here):
//   digit pattern: digit<=value, digit_valid<=1, blank<=0, pattern_err<=0.
//   blank: digit held, digit_valid<=0, blank<=1, pattern_err<=0.
//   illegal: digit held, digit_valid<=0, blank<=0, pattern_err<=1.
//  new_digit=1 for exactly the acceptance cycle iff accepted digit and (previous digit_valid=0 or
//   value!=digit); change_cnt increments on that same edge. new_digit=0 in all other cycles.
//  sample_en=0: state, cand, stab_cnt, outputs held; new_digit forced 0. Glitches shorter than
//   STABLE_CYCLES samples never reach outputs but restart the count.
//  blank, digit_valid, pattern_err mutually exclusive; all 0 only in EMPTY after reset.
// CONFIGURATION
//  SEG_ERR_CNT_EN defined: extra port err_cnt out CNT_W, reset 0, +1 on each acceptance of an
//   illegal pattern, saturates at all-ones. Undefined: port and logic absent, rest identical.
// TESTING (STABLE_CYCLES=4, CNT_W=8, sample_en=1 unless stated)
//  1. rst then seg_in=0010010 held 4 edges -> edge 4: digit=2, digit_valid=1, new_digit pulse, change_cnt=1.
//  2. From locked 2: 1-, 2-, 3-edge glitch to 0000000 then back -> no output change, no pulse.
//  3. Sweep 0..9 each held 6 edges -> 10 pulses, change_cnt=10, digit follows table.
//  4. Apply 1111111 then 1010101 (4 edges each) -> blank=1 then pattern_err=1, digit held,
//     no pulse; with SEG_ERR_CNT_EN err_cnt=1; re-accept of same digit 3 after blank -> pulse.
//  5. sample_en=0 for 10 cycles mid-settle (stab_cnt=2) -> resume needs 2 more samples to accept.
//  6. rst asserted during SETTLE and with sample_en=1 -> all outputs at reset values next cycle;
//     STABLE_CYCLES=1 build accepts on first sample edge.

Source files
------------

// File: rtl/seg7_leitor_filtrado.sv
// ---------------------------------------------------------------------------
// seg7_leitor_filtrado
//
// Reads back an active-low 7-segment pattern bus ({a,b,c,d,e,f,g}) and
// recovers the decimal digit it represents. A stability filter only lets a
// pattern through after STABLE_CYCLES consecutive equal samples. Shorter
// glitches restart the count and never reach the outputs.
//
// Parameters
//   STABLE_CYCLES  consecutive equal samples needed to accept (1..255)
//   CNT_W          width of change_cnt / err_cnt
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   synchronous reset, active-high (overrides sample_en)
//   seg_in       in   [6:0] segment pattern, active-low
//   sample_en    in   sampling strobe; 0 freezes all state and outputs
//   digit        out  [3:0] last accepted digit 0..9
//   digit_valid  out  last accepted pattern was a legal digit
//   blank        out  last accepted pattern was all segments off
//   pattern_err  out  last accepted pattern was neither digit nor blank
//   new_digit    out  one-cycle pulse when a digit that differs from the
//                     previous one is accepted
//   change_cnt   out  [CNT_W-1:0] number of new_digit pulses, wraps
//   err_cnt      out  [CNT_W-1:0] illegal-pattern acceptances, saturating
//                     (present only when SEG_ERR_CNT_EN is defined)
//
// Build option: define SEG_ERR_CNT_EN to add the err_cnt port and counter.
// ---------------------------------------------------------------------------
module seg7_leitor_filtrado #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       seg_in,
  input  logic             sample_en,
  output logic [3:0]       digit,
  output logic             digit_valid,
  output logic             blank,
  output logic             pattern_err,
  output logic             new_digit,
`ifdef SEG_ERR_CNT_EN
  output logic [CNT_W-1:0] err_cnt,
`endif
  output logic [CNT_W-1:0] change_cnt
);

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [7:0] STAB_MAX = 8'(STABLE_CYCLES);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Returns {is_digit, value}; value is 0 when the pattern is not a digit.
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'b0000001: r = {1'b1, 4'd0};
      7'b1001111: r = {1'b1, 4'd1};
      7'b0010010: r = {1'b1, 4'd2};
      7'b0000110: r = {1'b1, 4'd3};
      7'b1001100: r = {1'b1, 4'd4};
      7'b0100100: r = {1'b1, 4'd5};
      7'b0100000: r = {1'b1, 4'd6};
      7'b0001111: r = {1'b1, 4'd7};
      7'b0000000: r = {1'b1, 4'd8};
      7'b0000100: r = {1'b1, 4'd9};
      default:    r = 5'b0_0000;
    endcase
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [6:0]       cand_q, cand_d;
  logic [7:0]       stab_q, stab_d;
  logic [3:0]       digit_q, digit_d;
  logic             valid_q, valid_d;
  logic             blank_q, blank_d;
  logic             err_q, err_d;
  logic             new_digit_q, new_digit_d;
  logic [CNT_W-1:0] change_cnt_q, change_cnt_d;
`ifdef SEG_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
`endif

  logic       seg_diff;
  logic       accept;
  logic [4:0] dec;
  logic       dec_is_digit;
  logic [3:0] dec_value;

  assign seg_diff     = (seg_in != cand_q);
  assign dec          = decode_seg(seg_in);
  assign dec_is_digit = dec[4];
  assign dec_value    = dec[3:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      cand_q       <= SEG_BLANK;
      stab_q       <= 8'd0;
      digit_q      <= 4'd0;
      valid_q      <= 1'b0;
      blank_q      <= 1'b0;
      err_q        <= 1'b0;
      new_digit_q  <= 1'b0;
      change_cnt_q <= '0;
`ifdef SEG_ERR_CNT_EN
      err_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cand_q       <= cand_d;
      stab_q       <= stab_d;
      digit_q      <= digit_d;
      valid_q      <= valid_d;
      blank_q      <= blank_d;
      err_q        <= err_d;
      new_digit_q  <= new_digit_d;
      change_cnt_q <= change_cnt_d;
`ifdef SEG_ERR_CNT_EN
      err_cnt_q    <= err_cnt_d;
`endif
    end
  end

  // Next-state: candidate tracking and stability count.
  // With STABLE_CYCLES=1 the load edge is itself the acceptance edge.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    stab_d  = stab_q;
    if (sample_en) begin
      if (seg_diff) begin
        cand_d  = seg_in;
        stab_d  = 8'd1;
        state_d = (STAB_MAX == 8'd1) ? LOCKED : SETTLE;
      end else if (stab_q < STAB_MAX) begin
        stab_d = stab_q + 8'd1;
        if (stab_q + 8'd1 == STAB_MAX) state_d = LOCKED;
      end
    end
  end

  // Outputs: acceptance is the transition into LOCKED, or a one-sample
  // reload that relocks immediately (STABLE_CYCLES=1 with a new pattern).
  always_comb begin
    accept       = sample_en && (state_d == LOCKED) &&
                   ((state_q != LOCKED) || seg_diff);
    digit_d      = digit_q;
    valid_d      = valid_q;
    blank_d      = blank_q;
    err_d        = err_q;
    new_digit_d  = 1'b0;
    change_cnt_d = change_cnt_q;
`ifdef SEG_ERR_CNT_EN
    err_cnt_d    = err_cnt_q;
`endif
    if (accept) begin
      if (dec_is_digit) begin
        new_digit_d = !valid_q || (dec_value != digit_q);
        digit_d     = dec_value;
        valid_d     = 1'b1;
        blank_d     = 1'b0;
        err_d       = 1'b0;
      end else if (seg_in == SEG_BLANK) begin
        valid_d = 1'b0;
        blank_d = 1'b1;
        err_d   = 1'b0;
      end else begin
        valid_d = 1'b0;
        blank_d = 1'b0;
        err_d   = 1'b1;
`ifdef SEG_ERR_CNT_EN
        if (err_cnt_q != {CNT_W{1'b1}}) err_cnt_d = err_cnt_q + CNT_W'(1);
`endif
      end
    end
    if (new_digit_d) change_cnt_d = change_cnt_q + CNT_W'(1);
  end

  assign digit       = digit_q;
  assign digit_valid = valid_q;
  assign blank       = blank_q;
  assign pattern_err = err_q;
  assign new_digit   = new_digit_q;
  assign change_cnt  = change_cnt_q;
`ifdef SEG_ERR_CNT_EN
  assign err_cnt     = err_cnt_q;
`endif

endmodule

// File: tb/tb_seg7_leitor_filtrado.sv
module tb_seg7_leitor_filtrado;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg_in;
  logic       sample_en;

  logic [3:0] d0_digit, d1_digit;
  logic       d0_valid, d1_valid, d0_blank, d1_blank, d0_err, d1_err;
  logic       d0_nd, d1_nd;
  logic [7:0] d0_cnt, d1_cnt;
`ifdef SEG_ERR_CNT_EN
  logic [7:0] d0_ecnt, d1_ecnt;
`endif

  always #5 clk = ~clk;

  seg7_leitor_filtrado #(.STABLE_CYCLES(4), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .seg_in(seg_in), .sample_en(sample_en),
    .digit(d0_digit), .digit_valid(d0_valid), .blank(d0_blank),
    .pattern_err(d0_err), .new_digit(d0_nd),
`ifdef SEG_ERR_CNT_EN
    .err_cnt(d0_ecnt),
`endif
    .change_cnt(d0_cnt)
  );

  seg7_leitor_filtrado #(.STABLE_CYCLES(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .seg_in(seg_in), .sample_en(sample_en),
    .digit(d1_digit), .digit_valid(d1_valid), .blank(d1_blank),
    .pattern_err(d1_err), .new_digit(d1_nd),
`ifdef SEG_ERR_CNT_EN
    .err_cnt(d1_ecnt),
`endif
    .change_cnt(d1_cnt)
  );

  logic [6:0] TBL [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                           7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                           7'b0000000, 7'b0000100};

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: run length of identical enabled samples; a pattern is
  // accepted exactly when its run length reaches the required count.
  int m_val[2], m_run[2], m_dig[2], m_valid[2], m_blank[2], m_err[2];
  int m_nd[2], m_cnt[2], m_ecnt[2];

  function automatic int need(input int m);
    return (m == 0) ? 4 : 1;
  endfunction

  function automatic int lookup(input logic [6:0] s);
    for (int i = 0; i < 10; i++) if (TBL[i] == s) return i;
    return -1;
  endfunction

  task automatic model_edge(input int m, input logic [6:0] s, input logic e, input logic r);
    int d;
    m_nd[m] = 0;
    if (r) begin
      m_val[m] = 127; m_run[m] = 0; m_dig[m] = 0; m_valid[m] = 0;
      m_blank[m] = 0; m_err[m] = 0; m_cnt[m] = 0; m_ecnt[m] = 0;
    end else if (e) begin
      if (int'(s) != m_val[m]) begin
        m_val[m] = int'(s);
        m_run[m] = 1;
      end else if (m_run[m] < 1000) begin
        m_run[m] = m_run[m] + 1;
      end
      if (m_run[m] == need(m)) begin
        d = lookup(s);
        if (d >= 0) begin
          if (m_valid[m] == 0 || d != m_dig[m]) begin
            m_nd[m] = 1;
            m_cnt[m] = (m_cnt[m] + 1) % 256;
          end
          m_dig[m] = d; m_valid[m] = 1; m_blank[m] = 0; m_err[m] = 0;
        end else if (s == 7'h7F) begin
          m_valid[m] = 0; m_blank[m] = 1; m_err[m] = 0;
        end else begin
          m_valid[m] = 0; m_blank[m] = 0; m_err[m] = 1;
          if (m_ecnt[m] < 255) m_ecnt[m] = m_ecnt[m] + 1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("s4_digit", 32'(d0_digit), m_dig[0]);
    chk("s4_valid", 32'(d0_valid), m_valid[0]);
    chk("s4_blank", 32'(d0_blank), m_blank[0]);
    chk("s4_err",   32'(d0_err),   m_err[0]);
    chk("s4_newd",  32'(d0_nd),    m_nd[0]);
    chk("s4_cnt",   32'(d0_cnt),   m_cnt[0]);
    chk("s1_digit", 32'(d1_digit), m_dig[1]);
    chk("s1_valid", 32'(d1_valid), m_valid[1]);
    chk("s1_blank", 32'(d1_blank), m_blank[1]);
    chk("s1_err",   32'(d1_err),   m_err[1]);
    chk("s1_newd",  32'(d1_nd),    m_nd[1]);
    chk("s1_cnt",   32'(d1_cnt),   m_cnt[1]);
`ifdef SEG_ERR_CNT_EN
    chk("s4_ecnt",  32'(d0_ecnt),  m_ecnt[0]);
    chk("s1_ecnt",  32'(d1_ecnt),  m_ecnt[1]);
`endif
  endtask

  task automatic step(input logic [6:0] s, input logic e, input logic r);
    seg_in    = s;
    sample_en = e;
    rst       = r;
    @(posedge clk);
    model_edge(0, s, e, r);
    model_edge(1, s, e, r);
    #1;
    check_all();
  endtask

  task automatic hold(input logic [6:0] s, input int n);
    for (int i = 0; i < n; i++) step(s, 1'b1, 1'b0);
  endtask

  int pulses;

  initial begin
    rst = 1'b1; seg_in = 7'h7F; sample_en = 1'b1;

    // Reset state
    step(7'h7F, 1'b1, 1'b1);
    chk("rst_valid", 32'(d0_valid), 0);
    chk("rst_cnt",   32'(d0_cnt), 0);

    // 1: digit 2 accepted on the fourth edge
    hold(TBL[2], 3);
    chk("t1_pre_valid", 32'(d0_valid), 0);
    hold(TBL[2], 1);
    chk("t1_digit", 32'(d0_digit), 2);
    chk("t1_pulse", 32'(d0_nd), 1);
    chk("t1_cnt",   32'(d0_cnt), 1);

    // 2: short glitches to 8 never reach the outputs of the 4-sample filter
    for (int g = 1; g <= 3; g++) begin
      hold(TBL[8], g);
      hold(TBL[2], 5);
      chk("t2_digit", 32'(d0_digit), 2);
      chk("t2_cnt",   32'(d0_cnt), 1);
    end

    // 3: sweep 0..9 from reset
    step(7'h7F, 1'b1, 1'b1);
    pulses = 0;
    for (int d = 0; d < 10; d++) begin
      for (int i = 0; i < 6; i++) begin
        step(TBL[d], 1'b1, 1'b0);
        if (d0_nd) pulses++;
      end
      chk("t3_digit", 32'(d0_digit), d);
    end
    chk("t3_pulses", pulses, 10);
    chk("t3_cnt", 32'(d0_cnt), 10);

    // 4: blank, illegal, then digit 3 re-accepted
    hold(7'b1111111, 4);
    chk("t4_blank", 32'(d0_blank), 1);
    chk("t4_hold",  32'(d0_digit), 9);
    hold(7'b1010101, 4);
    chk("t4_err",   32'(d0_err), 1);
    chk("t4_cnt",   32'(d0_cnt), 10);
`ifdef SEG_ERR_CNT_EN
    chk("t4_ecnt",  32'(d0_ecnt), 1);
`endif
    hold(TBL[3], 4);
    chk("t4_pulse", 32'(d0_nd), 1);
    hold(TBL[3], 2);
    hold(7'h7F, 4);
    hold(TBL[3], 4);
    chk("t4_repulse", 32'(d0_nd), 1);

    // 5: freeze mid-settle
    hold(TBL[5], 2);
    for (int i = 0; i < 10; i++) step(TBL[5], 1'b0, 1'b0);
    chk("t5_frozen", 32'(d0_digit), 3);
    hold(TBL[5], 1);
    chk("t5_not_yet", 32'(d0_digit), 3);
    hold(TBL[5], 1);
    chk("t5_accept", 32'(d0_digit), 5);

    // 6: reset during SETTLE with sample_en=1
    hold(TBL[7], 2);
    step(TBL[7], 1'b1, 1'b1);
    chk("t6_digit", 32'(d0_digit), 0);
    chk("t6_valid", 32'(d0_valid), 0);
    step(TBL[6], 1'b1, 1'b0);
    chk("t6_s1_digit", 32'(d1_digit), 6);

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      int sel, len;
      logic [6:0] s;
      logic e, r;
      sel = $urandom_range(0, 11);
      if (sel < 10) s = TBL[sel];
      else if (sel == 10) s = 7'h7F;
      else s = 7'($urandom);
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        e = ($urandom_range(0, 9) != 0);
        r = ($urandom_range(0, 99) == 0);
        step(s, e, r);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
